hwpe_eai_slave: RTL and testbench
=================================

// Module: hwpe_eai_slave
// PURPOSE
//  Accelerator-side endpoint of the EAI coprocessor interface. Accepts custom instructions from the core
//  over the request channel and executes one at a time: config write, config read, soft reset,
//  load-to-config, store-from-operand. Returns the result with the request's itag on the response channel.
//  Masters the ICB memory channel and drives mem_holdup. Feeds cfg_regs to the HWPE datapath.
// PARAMETERS
//  NUM_CFG  8  number of 32-bit config registers
//  CFG_AW   3  config index width; CFG_AW = clog2(NUM_CFG)
// PORTS
//  clk                clock input      1            single clock, rising edge
//  rst_n              input            1            asynchronous active-low reset
//  eai_req_valid      input            1            instruction valid from core
//  eai_req_ready      output           1            block can accept an instruction
//  eai_req_instr      input            32           instruction; funct7 = instr[31:25]
//  eai_req_rs1        input            32           operand 1: config index or memory address
//  eai_req_rs2        input            32           operand 2: write data or config index
//  eai_req_itag       input            2            instruction tag, echoed on response
//  eai_rsp_valid      output           1            result valid
//  eai_rsp_ready      input            1            core accepts result
//  eai_rsp_wdat       output           32           result data (rd write-back)
//  eai_rsp_itag       output           2            tag of the retiring instruction
//  eai_rsp_err        output           1            illegal funct7 or ICB error
//  eai_icb_cmd_valid  output           1            memory command valid
//  eai_icb_cmd_ready  input            1            memory command accepted
//  eai_icb_cmd_addr   output           32           {rs1[31:2],2'b00}
//  eai_icb_cmd_read   output           1            1 = load, 0 = store
//  eai_icb_cmd_wdata  output           32           store data (rs2)
//  eai_icb_cmd_wmask  output           4            4'hF for store, 4'h0 for load
//  eai_icb_rsp_valid  input            1            memory response valid
//  eai_icb_rsp_ready  output           1            high only in MEM_RSP
//  eai_icb_rsp_rdata  input            32           load data
//  eai_icb_rsp_err    input            1            bus error
//  eai_mem_holdup     output           1            high from accept of LOAD/STORE until its ICB rsp handshake
//  cfg_regs           output           NUM_CFG*32   flattened config regs; reg i at [32*i+:32]
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; all outputs 0 except eai_req_ready=1; cfg_regs=0; captured fields=0.
//  - FSM: IDLE -> EXEC (register op) | MEM_CMD (LOAD/STORE); MEM_CMD -> MEM_RSP on cmd handshake;
//    MEM_RSP -> RSP on icb rsp handshake; EXEC -> RSP unconditionally; RSP -> IDLE on rsp handshake.
//  - eai_req_ready = (state==IDLE). Depends on state only, never on req_valid. Accept = valid&ready.
//    On accept, latch instr funct7, rs1, rs2, itag.
//  - Decode uses funct7 macros from hwpe_define.vh:
//    `HWPECfgW: cfg[rs1[CFG_AW-1:0]] <= rs2; wdat = rs2.
//    `HWPECfgR: wdat = cfg[rs1[CFG_AW-1:0]].
//    `HWPEReset: all cfg <= 0; wdat = 0.
//    `HWPELoad: ICB read at rs1; cfg[rs2[CFG_AW-1:0]] <= rdata; wdat = rdata.
//    `HWPEStore: ICB write rs2 to rs1; wdat = 0.
//    Any other funct7: no side effect; wdat = 0; err = 1.
//    Index bits above CFG_AW are ignored.
//  - Latency: register op, accept in cycle T -> rsp_valid in T+2 (EXEC in T+1, RSP in T+2).
//    Memory op: cmd_valid in T+1; rsp_valid one cycle after the icb rsp handshake.
//  - cmd_valid and its payload stay stable until cmd_ready. rsp_valid, wdat, itag and err stay stable
//    until rsp_ready. No new request is taken while rsp_valid=1.
//  - ICB error: cfg is not written; wdat = 0; err = 1.
//  - rsp_ready=1 in the same cycle rsp_valid rises: retire in that cycle; req_ready=1 in the next cycle.
//  - Reset mid-operation: outstanding ICB or EAI transaction is dropped; no response is issued.
// STRUCTURE
//  - funct7 codes: shared hwpe_define.vh (alongside existing `HWPEReset).
//  - FSM state encodings: shared hwpe_define.vh.
//  - One sub-module: hwpe_cfg_regfile (NUM_CFG x 32; one write port, one read port, sync clear).
//  - FSM and decode inline.
// TESTING
//  1. CfgW rs1=3, rs2=32'hDEADBEEF, itag=2 -> rsp 2 cycles later: wdat=DEADBEEF, itag=2, err=0;
//     cfg_regs[127:96]=DEADBEEF.
//  2. CfgR rs1=3 after test 1, rsp_ready held 0 for 5 cycles -> rsp_valid and DEADBEEF stable;
//     req_ready=0 throughout; one retire.
//  3. Load rs1=32'h1003, rs2=1, mem returns 32'h12345678 -> cmd_addr=32'h1000, read=1;
//     holdup high until rsp handshake; cfg[1]=12345678; wdat=12345678.
//  4. Store rs1=32'h20, rs2=32'hA5A5A5A5, cmd_ready delayed 3 cycles -> payload stable;
//     wmask=F; wdat=0; err=0.
//  5. Illegal funct7, then Load with icb_rsp_err=1 -> both err=1, wdat=0, cfg unchanged;
//     itags increment 0,1.
//  6. Assert rst_n=0 while in MEM_RSP -> all outputs 0, req_ready=1; next CfgR of any index returns 0.

Source files
------------

// File: rtl/hwpe_eai_slave_pkg.sv
// Shared definitions for the HWPE EAI endpoint: funct7 opcodes, FSM states and sizing.
package hwpe_eai_slave_pkg;

  localparam int unsigned NumCfg = 8;
  localparam int unsigned CfgAw  = $clog2(NumCfg);

  localparam logic [6:0] HwpeCfgW  = 7'h01;
  localparam logic [6:0] HwpeCfgR  = 7'h02;
  localparam logic [6:0] HwpeReset = 7'h03;
  localparam logic [6:0] HwpeLoad  = 7'h04;
  localparam logic [6:0] HwpeStore = 7'h05;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StMemCmd,
    StMemRsp,
    StRsp
  } eai_state_e;

  function automatic logic is_mem_op(input logic [6:0] funct7);
    return (funct7 == HwpeLoad) || (funct7 == HwpeStore);
  endfunction

endpackage

// File: rtl/hwpe_eai_slave_cfg_regfile.sv
// NUM_CFG x 32 configuration register file: one write port, one async read port, sync clear.
module hwpe_cfg_regfile #(
  parameter int unsigned NUM_CFG = 8,
  parameter int unsigned CFG_AW  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  we,
  input  logic [CFG_AW-1:0]     waddr,
  input  logic [31:0]           wdata,
  input  logic [CFG_AW-1:0]     raddr,
  output logic [31:0]           rdata,
  output logic [NUM_CFG*32-1:0] cfg_flat
);

  logic [NUM_CFG-1:0][31:0] regs_q;

  // Clear wins over a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else if (clr) begin
      regs_q <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata    = regs_q[raddr];
  assign cfg_flat = regs_q;

endmodule

// File: rtl/hwpe_eai_slave.sv
// EAI coprocessor endpoint: executes one custom instruction at a time, masters ICB for LOAD/STORE.
module hwpe_eai_slave
  import hwpe_eai_slave_pkg::*;
#(
  parameter int unsigned NUM_CFG = NumCfg,
  parameter int unsigned CFG_AW  = CfgAw
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  eai_req_valid,
  output logic                  eai_req_ready,
  input  logic [31:0]           eai_req_instr,
  input  logic [31:0]           eai_req_rs1,
  input  logic [31:0]           eai_req_rs2,
  input  logic [1:0]            eai_req_itag,
  output logic                  eai_rsp_valid,
  input  logic                  eai_rsp_ready,
  output logic [31:0]           eai_rsp_wdat,
  output logic [1:0]            eai_rsp_itag,
  output logic                  eai_rsp_err,
  output logic                  eai_icb_cmd_valid,
  input  logic                  eai_icb_cmd_ready,
  output logic [31:0]           eai_icb_cmd_addr,
  output logic                  eai_icb_cmd_read,
  output logic [31:0]           eai_icb_cmd_wdata,
  output logic [3:0]            eai_icb_cmd_wmask,
  input  logic                  eai_icb_rsp_valid,
  output logic                  eai_icb_rsp_ready,
  input  logic [31:0]           eai_icb_rsp_rdata,
  input  logic                  eai_icb_rsp_err,
  output logic                  eai_mem_holdup,
  output logic [NUM_CFG*32-1:0] cfg_regs
);

  eai_state_e  state_q, state_d;
  logic [6:0]  funct7_q;
  logic [31:0] rs1_q, rs2_q;
  logic [1:0]  itag_q;
  logic [31:0] wdat_q, wdat_d;
  logic        err_q, err_d;

  logic              accept;
  logic              cfg_we, cfg_clr;
  logic [CFG_AW-1:0] cfg_waddr;
  logic [31:0]       cfg_wdata, cfg_rdata;

  logic unused_instr;
  assign unused_instr = ^eai_req_instr[24:0];

  assign eai_req_ready = (state_q == StIdle);
  assign accept        = eai_req_valid && eai_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      funct7_q <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      itag_q   <= '0;
      wdat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wdat_q  <= wdat_d;
      err_q   <= err_d;
      if (accept) begin
        funct7_q <= eai_req_instr[31:25];
        rs1_q    <= eai_req_rs1;
        rs2_q    <= eai_req_rs2;
        itag_q   <= eai_req_itag;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wdat_d    = wdat_q;
    err_d     = err_q;
    cfg_we    = 1'b0;
    cfg_clr   = 1'b0;
    cfg_waddr = rs1_q[CFG_AW-1:0];
    cfg_wdata = rs2_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = is_mem_op(eai_req_instr[31:25]) ? StMemCmd : StExec;
        end
      end
      StExec: begin
        state_d = StRsp;
        err_d   = 1'b0;
        wdat_d  = '0;
        unique case (funct7_q)
          HwpeCfgW: begin
            cfg_we = 1'b1;
            wdat_d = rs2_q;
          end
          HwpeCfgR:  wdat_d = cfg_rdata;
          HwpeReset: cfg_clr = 1'b1;
          default:   err_d = 1'b1;
        endcase
      end
      StMemCmd: begin
        if (eai_icb_cmd_ready) state_d = StMemRsp;
      end
      StMemRsp: begin
        if (eai_icb_rsp_valid) begin
          state_d = StRsp;
          err_d   = eai_icb_rsp_err;
          wdat_d  = '0;
          // A faulted load leaves the config untouched.
          if (funct7_q == HwpeLoad && !eai_icb_rsp_err) begin
            cfg_we    = 1'b1;
            cfg_waddr = rs2_q[CFG_AW-1:0];
            cfg_wdata = eai_icb_rsp_rdata;
            wdat_d    = eai_icb_rsp_rdata;
          end
        end
      end
      StRsp: begin
        if (eai_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  hwpe_cfg_regfile #(
    .NUM_CFG (NUM_CFG),
    .CFG_AW  (CFG_AW)
  ) u_cfg_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cfg_clr),
    .we       (cfg_we),
    .waddr    (cfg_waddr),
    .wdata    (cfg_wdata),
    .raddr    (rs1_q[CFG_AW-1:0]),
    .rdata    (cfg_rdata),
    .cfg_flat (cfg_regs)
  );

  assign eai_rsp_valid     = (state_q == StRsp);
  assign eai_rsp_wdat      = wdat_q;
  assign eai_rsp_itag      = itag_q;
  assign eai_rsp_err       = err_q;
  assign eai_icb_cmd_valid = (state_q == StMemCmd);
  assign eai_icb_cmd_addr  = {rs1_q[31:2], 2'b00};
  assign eai_icb_cmd_read  = (funct7_q == HwpeLoad);
  assign eai_icb_cmd_wdata = rs2_q;
  assign eai_icb_cmd_wmask = (funct7_q == HwpeStore) ? 4'hF : 4'h0;
  assign eai_icb_rsp_ready = (state_q == StMemRsp);
  assign eai_mem_holdup    = (state_q == StMemCmd) || (state_q == StMemRsp);

endmodule

// File: tb/tb_hwpe_eai_slave.sv
// Self-checking bench for hwpe_eai_slave: directed scenarios plus randomized ops vs. a config model.
module tb_hwpe_eai_slave;
  import hwpe_eai_slave_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         eai_req_valid = 1'b0, eai_req_ready;
  logic [31:0]  eai_req_instr = '0, eai_req_rs1 = '0, eai_req_rs2 = '0;
  logic [1:0]   eai_req_itag = '0;
  logic         eai_rsp_valid, eai_rsp_ready = 1'b0;
  logic [31:0]  eai_rsp_wdat;
  logic [1:0]   eai_rsp_itag;
  logic         eai_rsp_err;
  logic         eai_icb_cmd_valid, eai_icb_cmd_ready = 1'b0;
  logic [31:0]  eai_icb_cmd_addr, eai_icb_cmd_wdata;
  logic         eai_icb_cmd_read;
  logic [3:0]   eai_icb_cmd_wmask;
  logic         eai_icb_rsp_valid = 1'b0, eai_icb_rsp_ready;
  logic [31:0]  eai_icb_rsp_rdata = '0;
  logic         eai_icb_rsp_err = 1'b0;
  logic         eai_mem_holdup;
  logic [255:0] cfg_regs;

  always #5 clk = ~clk;

  hwpe_eai_slave u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .eai_req_valid     (eai_req_valid),
    .eai_req_ready     (eai_req_ready),
    .eai_req_instr     (eai_req_instr),
    .eai_req_rs1       (eai_req_rs1),
    .eai_req_rs2       (eai_req_rs2),
    .eai_req_itag      (eai_req_itag),
    .eai_rsp_valid     (eai_rsp_valid),
    .eai_rsp_ready     (eai_rsp_ready),
    .eai_rsp_wdat      (eai_rsp_wdat),
    .eai_rsp_itag      (eai_rsp_itag),
    .eai_rsp_err       (eai_rsp_err),
    .eai_icb_cmd_valid (eai_icb_cmd_valid),
    .eai_icb_cmd_ready (eai_icb_cmd_ready),
    .eai_icb_cmd_addr  (eai_icb_cmd_addr),
    .eai_icb_cmd_read  (eai_icb_cmd_read),
    .eai_icb_cmd_wdata (eai_icb_cmd_wdata),
    .eai_icb_cmd_wmask (eai_icb_cmd_wmask),
    .eai_icb_rsp_valid (eai_icb_rsp_valid),
    .eai_icb_rsp_ready (eai_icb_rsp_ready),
    .eai_icb_rsp_rdata (eai_icb_rsp_rdata),
    .eai_icb_rsp_err   (eai_icb_rsp_err),
    .eai_mem_holdup    (eai_mem_holdup),
    .cfg_regs          (cfg_regs)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] m_cfg [8];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[32*i +: 32] = m_cfg[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full instruction: issue, serve ICB if needed, check response against the model, retire.
  task automatic run_op(input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [1:0] itag, input logic [31:0] rdata, input logic berr,
                        input int cmd_wait, input int rsp_wait, input int rdy_wait);
    logic [31:0] exp_wdat;
    logic        exp_err;
    logic        mem;
    mem = (f7 == HwpeLoad) || (f7 == HwpeStore);
    chk("req_ready_idle", eai_req_ready, 1);
    eai_req_valid = 1'b1;
    eai_req_instr = {f7, 25'($urandom)};
    eai_req_rs1   = rs1;
    eai_req_rs2   = rs2;
    eai_req_itag  = itag;
    tick();
    eai_req_valid = 1'b0;
    eai_req_rs1   = $urandom;
    eai_req_rs2   = $urandom;
    if (mem) begin
      for (int i = 0; i <= cmd_wait; i++) begin
        chk("cmd_valid", eai_icb_cmd_valid, 1);
        chk("cmd_addr", eai_icb_cmd_addr, {rs1[31:2], 2'b00});
        chk("cmd_read", eai_icb_cmd_read, f7 == HwpeLoad);
        chk("cmd_wmask", eai_icb_cmd_wmask, (f7 == HwpeStore) ? 4'hF : 4'h0);
        if (f7 == HwpeStore) chk("cmd_wdata", eai_icb_cmd_wdata, rs2);
        chk("holdup_cmd", eai_mem_holdup, 1);
        chk("req_ready_busy", eai_req_ready, 0);
        if (i == cmd_wait) eai_icb_cmd_ready = 1'b1;
        tick();
      end
      eai_icb_cmd_ready = 1'b0;
      for (int i = 0; i <= rsp_wait; i++) begin
        chk("cmd_valid_done", eai_icb_cmd_valid, 0);
        chk("icb_rsp_ready", eai_icb_rsp_ready, 1);
        chk("holdup_rsp", eai_mem_holdup, 1);
        chk("rsp_valid_early", eai_rsp_valid, 0);
        if (i == rsp_wait) begin
          eai_icb_rsp_valid = 1'b1;
          eai_icb_rsp_rdata = rdata;
          eai_icb_rsp_err   = berr;
        end
        tick();
      end
      eai_icb_rsp_valid = 1'b0;
      eai_icb_rsp_err   = 1'b0;
    end else begin
      chk("rsp_valid_exec", eai_rsp_valid, 0);
      tick();
    end
    exp_wdat = '0;
    exp_err  = 1'b0;
    case (f7)
      HwpeCfgW: begin m_cfg[rs1 % 8] = rs2; exp_wdat = rs2; end
      HwpeCfgR: exp_wdat = m_cfg[rs1 % 8];
      HwpeReset: for (int i = 0; i < 8; i++) m_cfg[i] = '0;
      HwpeLoad: begin
        exp_err = berr;
        if (!berr) begin m_cfg[rs2 % 8] = rdata; exp_wdat = rdata; end
      end
      HwpeStore: exp_err = berr;
      default: exp_err = 1'b1;
    endcase
    for (int i = 0; i <= rdy_wait; i++) begin
      chk("rsp_valid", eai_rsp_valid, 1);
      chk("rsp_wdat", eai_rsp_wdat, exp_wdat);
      chk("rsp_itag", eai_rsp_itag, itag);
      chk("rsp_err", eai_rsp_err, exp_err);
      chk("req_ready_rsp", eai_req_ready, 0);
      chk("holdup_off", eai_mem_holdup, 0);
      chk("cfg_regs", cfg_regs, model_flat());
      if (i == rdy_wait) eai_rsp_ready = 1'b1;
      tick();
    end
    eai_rsp_ready = 1'b0;
    chk("rsp_retired", eai_rsp_valid, 0);
    chk("req_ready_back", eai_req_ready, 1);
  endtask

  initial begin
    logic [6:0] ops [6];
    ops = '{HwpeCfgW, HwpeCfgR, HwpeReset, HwpeLoad, HwpeStore, 7'h7F};
    for (int i = 0; i < 8; i++) m_cfg[i] = '0;

    #12;
    chk("rst_req_ready", eai_req_ready, 1);
    chk("rst_rsp_valid", eai_rsp_valid, 0);
    chk("rst_wdat", eai_rsp_wdat, 0);
    chk("rst_itag", eai_rsp_itag, 0);
    chk("rst_err", eai_rsp_err, 0);
    chk("rst_cmd_valid", eai_icb_cmd_valid, 0);
    chk("rst_cmd_addr", eai_icb_cmd_addr, 0);
    chk("rst_cmd_read", eai_icb_cmd_read, 0);
    chk("rst_cmd_wmask", eai_icb_cmd_wmask, 0);
    chk("rst_icb_rsp_ready", eai_icb_rsp_ready, 0);
    chk("rst_holdup", eai_mem_holdup, 0);
    chk("rst_cfg", cfg_regs, 0);
    rst_n = 1'b1;
    tick();

    run_op(HwpeCfgW, 32'd3, 32'hDEADBEEF, 2'd2, '0, 1'b0, 0, 0, 0);
    chk("cfg3_slice", cfg_regs[127:96], 32'hDEADBEEF);
    run_op(HwpeCfgR, 32'd3, 32'h0, 2'd1, '0, 1'b0, 0, 0, 5);
    run_op(HwpeLoad, 32'h1003, 32'd1, 2'd3, 32'h12345678, 1'b0, 0, 1, 0);
    chk("cfg1_slice", cfg_regs[63:32], 32'h12345678);
    run_op(HwpeStore, 32'h20, 32'hA5A5A5A5, 2'd0, '0, 1'b0, 3, 0, 0);
    run_op(7'h7F, 32'd2, 32'h55, 2'd0, '0, 1'b0, 0, 0, 0);
    run_op(HwpeLoad, 32'h40, 32'd5, 2'd1, 32'hCAFEF00D, 1'b1, 0, 0, 0);
    run_op(HwpeCfgW, 32'hFFFF_FFF9, 32'h0BAD_CAFE, 2'd2, '0, 1'b0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      run_op(ops[$urandom_range(5)], $urandom, $urandom, 2'($urandom), $urandom,
             ($urandom_range(3) == 0), $urandom_range(2), $urandom_range(2), $urandom_range(2));
    end

    // Reset while waiting for the ICB response: everything drops, config clears.
    eai_req_valid = 1'b1;
    eai_req_instr = {HwpeLoad, 25'h0};
    eai_req_rs1   = 32'h100;
    eai_req_rs2   = 32'd4;
    tick();
    eai_req_valid = 1'b0;
    eai_icb_cmd_ready = 1'b1;
    tick();
    eai_icb_cmd_ready = 1'b0;
    chk("mid_icb_rsp_ready", eai_icb_rsp_ready, 1);
    rst_n = 1'b0;
    #2;
    chk("mrst_req_ready", eai_req_ready, 1);
    chk("mrst_rsp_valid", eai_rsp_valid, 0);
    chk("mrst_cmd_valid", eai_icb_cmd_valid, 0);
    chk("mrst_icb_rsp_ready", eai_icb_rsp_ready, 0);
    chk("mrst_holdup", eai_mem_holdup, 0);
    chk("mrst_wdat", eai_rsp_wdat, 0);
    chk("mrst_cfg", cfg_regs, 0);
    for (int i = 0; i < 8; i++) m_cfg[i] = '0;
    tick();
    rst_n = 1'b1;
    tick();
    run_op(HwpeCfgR, $urandom, 32'h0, 2'd3, '0, 1'b0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
